// File: rtl/float_accum_pkg.sv
// Shared definitions for the float accumulator sequencer.
// The sequencer and the accumulator must agree on ACC_LATENCY.
package float_accum_pkg;

  localparam int ACC_LATENCY = 4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_WAIT   = 3'd2,
    S_STREAM = 3'd3,
    S_DRAIN  = 3'd4
  } state_e;

endpackage

// File: rtl/float_accum_tag_pipe.sv
// Fixed-depth shift register carrying per-element tags alongside the accumulator pipeline.
module float_accum_tag_pipe #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] tag_i,
  output logic [WIDTH-1:0] tag_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    if (gi == 0) begin : g_head
      always_ff @(posedge clk) begin
        if (rst) stage_q[gi] <= '0;
        else     stage_q[gi] <= tag_i;
      end
    end else begin : g_body
      always_ff @(posedge clk) begin
        if (rst) stage_q[gi] <= '0;
        else     stage_q[gi] <= stage_q[gi-1];
      end
    end
  end

  assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/float_accum_sched.sv
// Job sequencer for one float accumulator: drives run/running, paces the element
// source, and tags finished window sums as they leave the accumulator.
module float_accum_sched
  import float_accum_pkg::*;
#(
  parameter int STRIDE_W    = 16,
  parameter int DELAY_W     = 7,
  parameter int CNT_W       = 16,
  parameter int ACC_LATENCY = float_accum_pkg::ACC_LATENCY
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [STRIDE_W-1:0] cfg_stride_m1,
  input  logic [CNT_W-1:0]    cfg_windows,
  input  logic [DELAY_W-1:0]  cfg_delay,
  output logic                acc_run,
  output logic                acc_running,
  output logic [STRIDE_W-1:0] acc_stride_m1,
  output logic [DELAY_W-1:0]  acc_delay0,
  output logic                elem_req,
  output logic                elem_last,
  output logic                out_valid,
  output logic                out_last,
  output logic                busy,
  output logic                done
);

  localparam int DRAIN_W = $clog2(ACC_LATENCY + 1);

  state_e               state_q, state_d;
  logic [STRIDE_W-1:0]  stride_q, stride_d;
  logic [STRIDE_W-1:0]  elem_cnt_q, elem_cnt_d;
  logic [CNT_W-1:0]     windows_q, windows_d;
  logic [CNT_W-1:0]     win_cnt_q, win_cnt_d;
  logic [DELAY_W-1:0]   delay_q, delay_d;
  logic [DELAY_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [DRAIN_W-1:0]   drain_cnt_q, drain_cnt_d;
  logic                 empty_done_q, empty_done_d;

  logic                 accept;
  logic                 elem_last_w;
  logic                 last_win_w;
  logic [1:0]           tag_in;
  logic [1:0]           tag_out;

  assign accept      = cfg_valid && (state_q == S_IDLE);
  assign elem_last_w = (state_q == S_STREAM) && (elem_cnt_q == stride_q);
  // Equality against windows-1 keeps the window counter from ever wrapping.
  assign last_win_w  = (win_cnt_q == (windows_q - CNT_W'(1)));

  always_comb begin
    state_d      = state_q;
    stride_d     = stride_q;
    elem_cnt_d   = elem_cnt_q;
    windows_d    = windows_q;
    win_cnt_d    = win_cnt_q;
    delay_d      = delay_q;
    wait_cnt_d   = wait_cnt_q;
    drain_cnt_d  = drain_cnt_q;
    empty_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          stride_d   = cfg_stride_m1;
          windows_d  = cfg_windows;
          delay_d    = cfg_delay;
          elem_cnt_d = '0;
          win_cnt_d  = '0;
          if (cfg_windows == '0) empty_done_d = 1'b1;
          else                   state_d      = S_RUN;
        end
      end
      S_RUN: begin
        wait_cnt_d = delay_q;
        state_d    = (delay_q == '0) ? S_STREAM : S_WAIT;
      end
      S_WAIT: begin
        wait_cnt_d = wait_cnt_q - DELAY_W'(1);
        if (wait_cnt_q == DELAY_W'(1)) state_d = S_STREAM;
      end
      S_STREAM: begin
        if (elem_last_w) begin
          elem_cnt_d = '0;
          if (last_win_w) begin
            state_d     = S_DRAIN;
            drain_cnt_d = DRAIN_W'(ACC_LATENCY - 1);
          end else begin
            win_cnt_d = win_cnt_q + CNT_W'(1);
          end
        end else begin
          elem_cnt_d = elem_cnt_q + STRIDE_W'(1);
        end
      end
      S_DRAIN: begin
        if (drain_cnt_q == '0) state_d     = S_IDLE;
        else                   drain_cnt_d = drain_cnt_q - DRAIN_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      stride_q     <= '0;
      elem_cnt_q   <= '0;
      windows_q    <= '0;
      win_cnt_q    <= '0;
      delay_q      <= '0;
      wait_cnt_q   <= '0;
      drain_cnt_q  <= '0;
      empty_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      stride_q     <= stride_d;
      elem_cnt_q   <= elem_cnt_d;
      windows_q    <= windows_d;
      win_cnt_q    <= win_cnt_d;
      delay_q      <= delay_d;
      wait_cnt_q   <= wait_cnt_d;
      drain_cnt_q  <= drain_cnt_d;
      empty_done_q <= empty_done_d;
    end
  end

  // Tags ride alongside the accumulator so out_valid lines up with its out0.
  assign tag_in = {elem_last_w & last_win_w, elem_last_w};

  float_accum_tag_pipe #(
    .DEPTH (ACC_LATENCY),
    .WIDTH (2)
  ) u_tag_pipe (
    .clk   (clk),
    .rst   (rst),
    .tag_i (tag_in),
    .tag_o (tag_out)
  );

  assign cfg_ready     = (state_q == S_IDLE);
  assign busy          = (state_q != S_IDLE);
  assign acc_run       = (state_q == S_RUN);
  assign acc_running   = busy;
  assign acc_stride_m1 = stride_q;
  assign acc_delay0    = delay_q;
  assign elem_req      = (state_q == S_STREAM);
  assign elem_last     = elem_last_w;
  assign out_valid     = tag_out[0];
  assign out_last      = tag_out[1];
  assign done          = (tag_out[0] & tag_out[1]) | empty_done_q;

endmodule

// File: tb/tb_float_accum_sched.sv
// Bench for float_accum_sched: cycle-level job model plus a window-sum scoreboard.
module tb_float_accum_sched;
  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_valid = 1'b0;
  logic [15:0] cfg_stride_m1 = '0;
  logic [15:0] cfg_windows = '0;
  logic [6:0]  cfg_delay = '0;
  logic        cfg_ready, acc_run, acc_running, elem_req, elem_last;
  logic        out_valid, out_last, busy, done;
  logic [15:0] acc_stride_m1;
  logic [6:0]  acc_delay0;

  float_accum_sched dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_stride_m1(cfg_stride_m1), .cfg_windows(cfg_windows), .cfg_delay(cfg_delay),
    .acc_run(acc_run), .acc_running(acc_running), .acc_stride_m1(acc_stride_m1),
    .acc_delay0(acc_delay0), .elem_req(elem_req), .elem_last(elem_last),
    .out_valid(out_valid), .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int     n_checks = 0;
  int     n_pass = 0;
  longint cyc = 0;
  bit     started = 0;

  // Job model: the whole job is described by its run cycle, first element and last element.
  bit          m_active = 0;
  longint      m_r = 0, m_t0 = 0, m_last = 0, m_s1 = 1;
  longint      m_empty_done = -1;
  logic [15:0] m_stride = '0;
  logic [6:0]  m_delay = '0;
  int          m_accepts = 0;

  longint ev_acc_cyc = 0, ev_first_req = -1, ev_done_cyc = -1;
  int     ev_req_cnt = 0, ev_last_cnt = 0, ev_ov_cnt = 0, ev_done_cnt = 0, ev_run_cnt = 0;

  // Element source and a behavioural accumulator fed from the DUT's own pacing.
  int unsigned in0 = 0;
  int unsigned acc_part = 0, m_part = 0, out0 = 0;
  int unsigned acc_pipe [LAT];
  int unsigned exp_q [$];

  function automatic bit f_busy(longint c);
    return m_active && c >= m_r && c <= m_last + LAT;
  endfunction
  function automatic bit f_req(longint c);
    return m_active && c >= m_t0 && c <= m_last;
  endfunction
  function automatic bit f_elast(longint c);
    return f_req(c) && (((c - m_t0) % m_s1) == m_s1 - 1);
  endfunction
  function automatic bit f_oval(longint c);
    return f_elast(c - LAT);
  endfunction
  function automatic bit f_olast(longint c);
    return f_oval(c) && ((c - LAT) == m_last);
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
  endtask

  initial begin
    for (int i = 0; i < LAT; i++) acc_pipe[i] = 0;
    forever begin
      @(negedge clk);
      if (started) begin
        chk("cfg_ready",   longint'(cfg_ready),   longint'(!f_busy(cyc)));
        chk("busy",        longint'(busy),        longint'(f_busy(cyc)));
        chk("acc_running", longint'(acc_running), longint'(f_busy(cyc)));
        chk("acc_run",     longint'(acc_run),     longint'(m_active && cyc == m_r));
        chk("elem_req",    longint'(elem_req),    longint'(f_req(cyc)));
        chk("elem_last",   longint'(elem_last),   longint'(f_elast(cyc)));
        chk("out_valid",   longint'(out_valid),   longint'(f_oval(cyc)));
        chk("out_last",    longint'(out_last),    longint'(f_olast(cyc)));
        chk("done",        longint'(done),        longint'(f_olast(cyc) || cyc == m_empty_done));
        chk("acc_stride_m1", longint'(acc_stride_m1), longint'(m_stride));
        chk("acc_delay0",    longint'(acc_delay0),    longint'(m_delay));
        if (elem_req) begin
          if (ev_req_cnt == 0) ev_first_req = cyc;
          ev_req_cnt++;
        end
        if (elem_last) ev_last_cnt++;
        if (out_valid) ev_ov_cnt++;
        if (acc_run)   ev_run_cnt++;
        if (done) begin ev_done_cnt++; ev_done_cyc = cyc; end
        out0 = acc_pipe[LAT-1];
        if (out_valid) begin
          if (exp_q.size() == 0) chk("window_sum_pending", 0, 1);
          else chk("window_sum", longint'(out0), longint'(exp_q.pop_front()));
        end
        if (f_req(cyc)) begin
          m_part += in0;
          if (f_elast(cyc)) begin exp_q.push_back(m_part); m_part = 0; end
        end
        for (int i = LAT - 1; i > 0; i--) acc_pipe[i] = acc_pipe[i-1];
        acc_pipe[0] = 0;
        if (elem_req) begin
          acc_part += in0;
          if (elem_last) begin acc_pipe[0] = acc_part; acc_part = 0; end
        end
      end
      @(posedge clk);
      if (rst) begin
        started = 1; m_active = 0; m_empty_done = -1;
        m_stride = '0; m_delay = '0;
        exp_q.delete(); m_part = 0; acc_part = 0;
      end else if (started && cfg_valid && !f_busy(cyc)) begin
        m_stride = cfg_stride_m1; m_delay = cfg_delay;
        m_accepts++;
        ev_acc_cyc = cyc; ev_first_req = -1; ev_done_cyc = -1;
        ev_req_cnt = 0; ev_last_cnt = 0; ev_ov_cnt = 0; ev_done_cnt = 0; ev_run_cnt = 0;
        if (cfg_windows == 0) begin
          m_active = 0; m_empty_done = cyc + 1;
        end else begin
          m_active = 1;
          m_r    = cyc + 1;
          m_t0   = m_r + 1 + longint'(cfg_delay);
          m_s1   = longint'(cfg_stride_m1) + 1;
          m_last = m_t0 + m_s1 * longint'(cfg_windows) - 1;
        end
      end
      cyc++;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1 in0 = $urandom_range(0, 1000);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) tick();
  endtask

  task automatic offer(input logic [15:0] s, input logic [15:0] w, input logic [6:0] d, input int max_wait);
    int  start;
    bit  got;
    start = m_accepts;
    got = 0;
    cfg_stride_m1 = s; cfg_windows = w; cfg_delay = d; cfg_valid = 1'b1;
    for (int i = 0; i < max_wait && !got; i++) begin
      tick();
      if (m_accepts != start) got = 1;
    end
    cfg_valid = 1'b0;
    if (!got) chk("accept_timeout", 0, 1);
  endtask

  task automatic check_t1(input string tag, input longint a);
    chk({tag, "_first_req"}, ev_first_req, a + 2);
    chk({tag, "_req_cnt"},   ev_req_cnt, 8);
    chk({tag, "_last_cnt"},  ev_last_cnt, 2);
    chk({tag, "_ov_cnt"},    ev_ov_cnt, 2);
    chk({tag, "_done_cyc"},  ev_done_cyc, a + 13);
    chk({tag, "_done_cnt"},  ev_done_cnt, 1);
  endtask

  initial begin
    longint a, a1;
    int     seen;
    rst = 1'b1;
    wait_cycles(3);
    rst = 1'b0;
    tick();
    chk("rst_cfg_ready", longint'(cfg_ready), 1);
    chk("rst_busy",      longint'(busy), 0);
    chk("rst_done",      longint'(done), 0);
    chk("rst_stride",    longint'(acc_stride_m1), 0);

    // Two 4-element windows, no delay.
    offer(16'd3, 16'd2, 7'd0, 20); a = ev_acc_cyc;
    wait_cycles(16);
    check_t1("t1", a);
    $display("job t1 stride_m1=3 windows=2 delay=0 accept=%0d done=%0d", a, ev_done_cyc);

    // Single-element windows after a delay of 5.
    offer(16'd0, 16'd3, 7'd5, 20); a = ev_acc_cyc;
    wait_cycles(16);
    chk("t2_first_req", ev_first_req, a + 7);
    chk("t2_req_cnt",   ev_req_cnt, 3);
    chk("t2_last_cnt",  ev_last_cnt, 3);
    chk("t2_ov_cnt",    ev_ov_cnt, 3);
    chk("t2_done_cyc",  ev_done_cyc, a + 13);
    $display("job t2 stride_m1=0 windows=3 delay=5 accept=%0d done=%0d", a, ev_done_cyc);

    // Empty job.
    offer(16'd0, 16'd0, 7'd9, 20); a = ev_acc_cyc;
    wait_cycles(4);
    chk("t3_done_cyc", ev_done_cyc, a + 1);
    chk("t3_done_cnt", ev_done_cnt, 1);
    chk("t3_req_cnt",  ev_req_cnt, 0);
    chk("t3_run_cnt",  ev_run_cnt, 0);
    $display("job t3 windows=0 accept=%0d done=%0d", a, ev_done_cyc);

    // Reset in the third streaming cycle, then a clean repeat of t1.
    offer(16'd3, 16'd2, 7'd0, 20); a = ev_acc_cyc;
    wait_cycles(3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t4_rst_ready",  longint'(cfg_ready), 1);
    chk("t4_rst_busy",   longint'(busy), 0);
    chk("t4_rst_req",    longint'(elem_req), 0);
    chk("t4_rst_stride", longint'(acc_stride_m1), 0);
    wait_cycles(16);
    chk("t4_ov_cnt",   ev_ov_cnt, 0);
    chk("t4_done_cnt", ev_done_cnt, 0);
    $display("job t4 aborted accept=%0d", a);
    offer(16'd3, 16'd2, 7'd0, 20); a = ev_acc_cyc;
    wait_cycles(16);
    check_t1("t4b", a);
    $display("job t4b stride_m1=3 windows=2 delay=0 accept=%0d done=%0d", a, ev_done_cyc);

    // cfg_valid held across two back-to-back jobs.
    cfg_stride_m1 = 16'd3; cfg_windows = 16'd2; cfg_delay = 7'd0; cfg_valid = 1'b1;
    seen = m_accepts; a1 = -1;
    for (int i = 0; i < 60 && m_accepts < seen + 2; i++) begin
      tick();
      if (m_accepts == seen + 1 && a1 < 0) a1 = ev_acc_cyc;
    end
    cfg_valid = 1'b0;
    a = ev_acc_cyc;
    chk("t5_two_accepts", m_accepts, seen + 2);
    chk("t5_second_accept", a, a1 + 14);
    wait_cycles(16);
    check_t1("t5", a);
    $display("job t5 back-to-back accepts=%0d,%0d done=%0d", a1, a, ev_done_cyc);

    // Full-width window with the maximum delay.
    offer(16'hFFFF, 16'd1, 7'd127, 20); a = ev_acc_cyc;
    wait_cycles(65680);
    chk("t6_first_req", ev_first_req, a + 1 + 128);
    chk("t6_req_cnt",   ev_req_cnt, 65536);
    chk("t6_last_cnt",  ev_last_cnt, 1);
    chk("t6_ov_cnt",    ev_ov_cnt, 1);
    chk("t6_done_cyc",  ev_done_cyc, a + 1 + 65667);
    $display("job t6 stride_m1=65535 windows=1 delay=127 accept=%0d done=%0d", a, ev_done_cyc);

    // Randomised jobs with occasional aborts.
    for (int j = 0; j < 30; j++) begin
      logic [15:0] s, w;
      logic [6:0]  d;
      s = 16'($urandom_range(0, 6));
      w = 16'($urandom_range(0, 4));
      d = 7'($urandom_range(0, 12));
      offer(s, w, d, 400);
      $display("job rnd%0d stride_m1=%0d windows=%0d delay=%0d accept=%0d", j, s, w, d, ev_acc_cyc);
      if ($urandom_range(0, 7) == 0) begin
        wait_cycles($urandom_range(1, 20));
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end
      wait_cycles($urandom_range(0, 3));
    end
    wait_cycles(80);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #15_000_000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
